// File: rtl/hyperram_ctrl.sv
// rtl/hyperram_ctrl.sv - single-outstanding 32-bit HyperRAM controller, 2x fixed latency, 4-byte linear bursts
module hyperram_ctrl #(
    parameter int LATENCY    = 6,
    parameter int RST_CYCLES = 200,
    parameter int CS_HIGH    = 4,
    parameter int RD_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [21:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wsel,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [7:0]  hb_dq_i,
    output logic [7:0]  hb_dq_o,
    output logic        hb_dq_oe,
    input  logic        hb_rwds_i,
    output logic        hb_rwds_o,
    output logic        hb_rwds_oe,
    output logic        hb_ck,
    output logic        hb_cs_n,
    output logic        hb_rst_n
);
    typedef enum logic [2:0] {S_PWRUP, S_IDLE, S_CA, S_LAT, S_DATA, S_DONE} state_t;

    localparam logic [15:0] L_RST_END  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] L_INIT_END = 16'(2 * RST_CYCLES - 1);
    localparam logic [15:0] L_CA_END   = 16'd5;
    localparam logic [15:0] L_LAT_END  = 16'(4 * LATENCY - 5);
    localparam logic [15:0] L_TMO_END  = 16'(RD_TIMEOUT - 1);
    localparam logic [15:0] L_CSH_END  = 16'(CS_HIGH - 1);

    // 48-bit command/address word for a 32-bit word address
    function automatic logic [47:0] ca_word(input logic we, input logic [21:0] addr);
        logic [22:0] hw;
        hw = {addr, 1'b0};
        return {~we, 1'b0, 1'b1, 9'b0, hw[22:3], 13'b0, hw[2:0]};
    endfunction

    function automatic logic [7:0] ca_byte(input logic [47:0] ca, input logic [2:0] idx);
        case (idx)
            3'd0:    return ca[47:40];
            3'd1:    return ca[39:32];
            3'd2:    return ca[31:24];
            3'd3:    return ca[23:16];
            3'd4:    return ca[15:8];
            3'd5:    return ca[7:0];
            default: return 8'h00;
        endcase
    endfunction

    state_t      r_state, w_state;
    logic [15:0] r_cnt, w_cnt;
    logic [1:0]  r_bcnt, w_bcnt;
    logic [31:0] r_acc, w_acc;
    logic        r_we;
    logic [21:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wsel;
    logic        r_rwds_q;
    logic        r_req_ready, w_req_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic [31:0] r_rsp_rdata, w_rsp_rdata;
    logic        r_rsp_err, w_rsp_err;
    logic [7:0]  r_dq_o, w_dq_o;
    logic        r_dq_oe, w_dq_oe;
    logic        r_rwds_o, w_rwds_o;
    logic        r_rwds_oe, w_rwds_oe;
    logic        r_ck, w_ck;
    logic        r_cs_n, w_cs_n;
    logic        r_hb_rst_n, w_hb_rst_n;
    logic        w_load, w_finish, w_err;
    logic        w_rwds_edge;
    logic [1:0]  w_lane;
    logic [47:0] w_ca;

    assign w_rwds_edge = hb_rwds_i ^ r_rwds_q;
    // Burst byte k lands in lane k^1: bytes go [15:8], [7:0], [31:24], [23:16]
    assign w_lane      = r_bcnt ^ 2'b01;
    assign w_ca        = ca_word(r_we, r_addr);

    // State, request latch and registered pad/host outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_PWRUP;
            r_cnt       <= '0;
            r_bcnt      <= '0;
            r_acc       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wsel      <= '0;
            r_rwds_q    <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_dq_o      <= '0;
            r_dq_oe     <= 1'b0;
            r_rwds_o    <= 1'b0;
            r_rwds_oe   <= 1'b0;
            r_ck        <= 1'b0;
            r_cs_n      <= 1'b1;
            r_hb_rst_n  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_bcnt      <= w_bcnt;
            r_acc       <= w_acc;
            r_rwds_q    <= hb_rwds_i;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_dq_o      <= w_dq_o;
            r_dq_oe     <= w_dq_oe;
            r_rwds_o    <= w_rwds_o;
            r_rwds_oe   <= w_rwds_oe;
            r_ck        <= w_ck;
            r_cs_n      <= w_cs_n;
            r_hb_rst_n  <= w_hb_rst_n;
            if (w_load) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wsel  <= req_wsel;
            end
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt + 16'd1;
        w_bcnt      = r_bcnt;
        w_acc       = r_acc;
        w_req_ready = r_req_ready;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_dq_o      = r_dq_o;
        w_dq_oe     = r_dq_oe;
        w_rwds_o    = r_rwds_o;
        w_rwds_oe   = r_rwds_oe;
        w_cs_n      = r_cs_n;
        w_hb_rst_n  = r_hb_rst_n;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_PWRUP: begin
                if (r_cnt == L_RST_END) w_hb_rst_n = 1'b1;
                if (r_cnt == L_INIT_END) begin
                    w_state     = S_IDLE;
                    w_cnt       = '0;
                    w_req_ready = 1'b1;
                end
            end
            S_IDLE: begin
                w_cnt = '0;
                if (req_valid && r_req_ready) begin
                    w_load      = 1'b1;
                    w_req_ready = 1'b0;
                    w_cs_n      = 1'b0;
                    w_dq_oe     = 1'b1;
                    w_dq_o      = ca_byte(ca_word(req_we, req_addr), 3'd0);
                    w_bcnt      = '0;
                    w_acc       = '0;
                    w_state     = S_CA;
                end
            end
            S_CA: begin
                w_dq_o = ca_byte(w_ca, r_cnt[2:0] + 3'd1);
                if (r_cnt == L_CA_END) begin
                    w_state = S_LAT;
                    w_cnt   = '0;
                    w_dq_oe = 1'b0;
                    w_dq_o  = '0;
                end
            end
            S_LAT, S_DATA: begin
                if (r_we) begin
                    if (r_state == S_LAT) begin
                        if (r_cnt == L_LAT_END) begin
                            w_state   = S_DATA;
                            w_cnt     = '0;
                            w_dq_oe   = 1'b1;
                            w_rwds_oe = 1'b1;
                            w_dq_o    = r_wdata[15:8];
                            w_rwds_o  = ~r_wsel[1];
                            w_bcnt    = 2'd1;
                        end
                    end else if (r_cnt == 16'd3) begin
                        w_finish = 1'b1;
                    end else begin
                        w_dq_o   = r_wdata[{w_lane, 3'b000} +: 8];
                        w_rwds_o = ~r_wsel[w_lane];
                        w_bcnt   = r_bcnt + 2'd1;
                    end
                end else if (w_rwds_edge) begin
                    // Every RWDS transition strobes one read byte, the first one included
                    w_acc[{w_lane, 3'b000} +: 8] = hb_dq_i;
                    w_cnt  = '0;
                    w_bcnt = r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) w_finish = 1'b1;
                    else                w_state  = S_DATA;
                end else if (r_cnt == L_TMO_END) begin
                    w_finish = 1'b1;
                    w_err    = 1'b1;
                end
            end
            S_DONE: begin
                if (r_cnt == L_CSH_END) begin
                    w_state     = S_IDLE;
                    w_cnt       = '0;
                    w_req_ready = 1'b1;
                end
            end
            default: begin
                w_state = S_PWRUP;
                w_cnt   = '0;
            end
        endcase
        if (w_finish) begin
            w_state     = S_DONE;
            w_cnt       = '0;
            w_cs_n      = 1'b1;
            w_dq_oe     = 1'b0;
            w_rwds_oe   = 1'b0;
            w_dq_o      = '0;
            w_rwds_o    = 1'b0;
            w_rsp_valid = 1'b1;
            w_rsp_err   = w_err;
            w_rsp_rdata = (r_we || w_err) ? 32'h0 : w_acc;
        end
        // hb_ck runs only while selected and starts low on the first CA cycle
        w_ck = ((w_state == S_CA) || (w_state == S_LAT) || (w_state == S_DATA))
               && (r_state != S_IDLE) ? ~r_ck : 1'b0;
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign hb_dq_o    = r_dq_o;
    assign hb_dq_oe   = r_dq_oe;
    assign hb_rwds_o  = r_rwds_o;
    assign hb_rwds_oe = r_rwds_oe;
    assign hb_ck      = r_ck;
    assign hb_cs_n    = r_cs_n;
    assign hb_rst_n   = r_hb_rst_n;
endmodule
